// File: rtl/instr_loader.sv
// Instruction loader: streams words into instruction memory, then sequences CPU reset and a run window.
// Optional LOADER_WRAP_EN: words past DEPTH wrap and overwrite from address 0 instead of being dropped.
module instr_loader #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned RUN_CYCLES = 10
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              LoadInstructions,
   input  logic [DATA_W-1:0] Instruction,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              run,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam int unsigned MAX_CYC = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
   localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);

   localparam logic [ADDR_W:0]  FULL     = (ADDR_W+1)'(DEPTH);
   localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(RUN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CPURST,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  wptr;
   logic [CYC_W-1:0]   cyc;

   // A new load may begin from any state except LOAD itself; it aborts a pending sequence.
   logic start_c;
   assign start_c = LoadInstructions && (state != S_LOAD);

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state      <= S_IDLE;
         wptr       <= '0;
         cyc        <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         run        <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
         overflow   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (start_c) begin
            // First word of a fresh load lands at address 0.
            state      <= S_LOAD;
            imem_we    <= 1'b1;
            imem_waddr <= '0;
            imem_wdata <= Instruction;
            wptr       <= ADDR_W'(1);
            count      <= (ADDR_W+1)'(1);
            overflow   <= 1'b0;
            cpu_reset  <= 1'b1;
            run        <= 1'b0;
            done       <= 1'b0;
            cyc        <= '0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (LoadInstructions) begin
                     if (count == FULL) begin
                        overflow <= 1'b1;
`ifdef LOADER_WRAP_EN
                        imem_we    <= 1'b1;
                        imem_waddr <= wptr;
                        imem_wdata <= Instruction;
                        wptr       <= wptr + ADDR_W'(1);
`else
                        imem_we    <= 1'b0;
`endif
                     end else begin
                        imem_we    <= 1'b1;
                        imem_waddr <= wptr;
                        imem_wdata <= Instruction;
                        wptr       <= wptr + ADDR_W'(1);
                        count      <= count + (ADDR_W+1)'(1);
                     end
                  end else begin
                     state <= S_CPURST;
                     cyc   <= '0;
                  end
               end
               S_CPURST: begin
                  if (cyc == RST_LAST) begin
                     state     <= S_RUN;
                     cyc       <= '0;
                     cpu_reset <= 1'b0;
                     run       <= 1'b1;
                  end else begin
                     cyc <= cyc + CYC_W'(1);
                  end
               end
               S_RUN: begin
                  if (cyc == RUN_LAST) begin
                     state <= S_DONE;
                     cyc   <= '0;
                     run   <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cyc <= cyc + CYC_W'(1);
                  end
               end
               S_IDLE, S_DONE: begin
                  state <= state;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_instr_loader;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned RST_CYCLES = 2;
   localparam int unsigned RUN_CYCLES = 10;

   logic              clk = 1'b0;
   logic              Reset;
   logic              LoadInstructions;
   logic [DATA_W-1:0] Instruction;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [DATA_W-1:0] imem_wdata;
   logic              cpu_reset;
   logic              run;
   logic              done;
   logic [ADDR_W:0]   count;
   logic              overflow;

   instr_loader #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .RST_CYCLES(RST_CYCLES), .RUN_CYCLES(RUN_CYCLES)
   ) dut (
      .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions), .Instruction(Instruction),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .run(run), .done(done), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: phase, time left in phase, and the list-position of the next word.
   localparam int M_IDLE = 0, M_LOAD = 1, M_RST = 2, M_RUN = 3, M_DONE = 4;
   int                m_mode  = M_IDLE;
   int                m_left  = 0;
   int                m_count = 0;
   int                m_ptr   = 0;
   bit                m_ovf   = 1'b0;
   bit                m_we    = 1'b0;
   logic [ADDR_W-1:0] m_waddr = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   bit                started = 1'b0;

   task automatic m_put(input logic [DATA_W-1:0] w);
      m_we    = 1'b1;
      m_waddr = ADDR_W'(m_ptr % DEPTH);
      m_wdata = w;
      m_ptr++;
   endtask

   task automatic model_step();
      m_we = 1'b0;
      if (!Reset) begin
         m_mode = M_IDLE; m_count = 0; m_ptr = 0; m_ovf = 1'b0;
         m_waddr = '0; m_wdata = '0;
      end else begin
         if (LoadInstructions && m_mode != M_LOAD) begin
            m_mode = M_LOAD; m_count = 0; m_ptr = 0; m_ovf = 1'b0;
         end
         case (m_mode)
            M_LOAD: begin
               if (LoadInstructions) begin
                  if (m_count == DEPTH) begin
                     m_ovf = 1'b1;
`ifdef LOADER_WRAP_EN
                     m_put(Instruction);
`endif
                  end else begin
                     m_put(Instruction);
                     m_count++;
                  end
               end else begin
                  m_mode = M_RST; m_left = RST_CYCLES;
               end
            end
            M_RST: begin
               m_left--;
               if (m_left == 0) begin m_mode = M_RUN; m_left = RUN_CYCLES; end
            end
            M_RUN: begin
               m_left--;
               if (m_left == 0) m_mode = M_DONE;
            end
            default: ;
         endcase
      end
      started = 1'b1;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Observed memory writes, used by the literal checks.
   logic [DATA_W-1:0] dut_mem [DEPTH];
   int                wr_cnt = 0;

   task automatic compare();
      bit exp_rst;
      if (!started) return;
      exp_rst = (m_mode == M_IDLE) || (m_mode == M_LOAD) || (m_mode == M_RST);
      chk("imem_we", 64'(imem_we), 64'(m_we));
      if (m_we) begin
         chk("imem_waddr", 64'(imem_waddr), 64'(m_waddr));
         chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
      end
      chk("cpu_reset", 64'(cpu_reset), 64'(exp_rst));
      chk("run", 64'(run), 64'(m_mode == M_RUN));
      chk("done", 64'(done), 64'(m_mode == M_DONE));
      chk("count", 64'(count), 64'(m_count));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (imem_we === 1'b1) begin
         dut_mem[imem_waddr] = imem_wdata;
         wr_cnt++;
      end
   endtask

   initial forever begin
      @(negedge clk);
      compare();
   end

   logic [DATA_W-1:0] wq[$];

   task automatic clear_log();
      for (int i = 0; i < int'(DEPTH); i++) dut_mem[i] = '0;
      wr_cnt = 0;
   endtask

   task automatic load_seq(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         LoadInstructions = 1'b1;
         Instruction      = wq[i];
      end
      @(negedge clk);
      LoadInstructions = 1'b0;
   endtask

   task automatic wait_done(input string name, output int rst_n, output int run_n);
      bit seen = 1'b0;
      rst_n = 0;
      run_n = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (run) run_n++;
         else if (cpu_reset) rst_n++;
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_n, run_n, rc, we_n;
      Reset = 1'b0;
      LoadInstructions = 1'b0;
      Instruction = '0;
      clear_log();

      // Reset state
      @(negedge clk);
      chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("rst_imem_we", 64'(imem_we), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_run", 64'(run), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      Reset = 1'b1;

      // 11-word load, full CPU sequence
      wq.delete();
      wq.push_back(32'h200001A7);
      for (int i = 1; i < 10; i++) wq.push_back(32'h1000_0000 + 32'(i * 32'h111));
      wq.push_back(32'h00E24020);
      clear_log();
      load_seq(11);
      wait_done("t1_done_seen", rst_n, run_n);
      chk("t1_writes", 64'(wr_cnt), 64'd11);
      chk("t1_mem0", 64'(dut_mem[0]), 64'h200001A7);
      chk("t1_mem10", 64'(dut_mem[10]), 64'h00E24020);
      chk("t1_count", 64'(count), 64'd11);
      chk("t1_rst_cycles", 64'(rst_n), 64'd2);
      chk("t1_run_cycles", 64'(run_n), 64'd10);
      chk("t1_overflow", 64'(overflow), 64'd0);

      // 18-word load into a 16-deep memory, started from DONE
      wq.delete();
      for (int i = 0; i < 18; i++) wq.push_back(32'h3000_0000 + 32'(i));
      clear_log();
      load_seq(18);
      @(negedge clk);
      chk("t2_count", 64'(count), 64'd16);
      chk("t2_overflow", 64'(overflow), 64'd1);
`ifdef LOADER_WRAP_EN
      chk("t2_writes", 64'(wr_cnt), 64'd18);
      chk("t2_mem0", 64'(dut_mem[0]), 64'h3000_0010);
      chk("t2_mem1", 64'(dut_mem[1]), 64'h3000_0011);
      chk("t2_mem2", 64'(dut_mem[2]), 64'h3000_0002);
`else
      chk("t2_writes", 64'(wr_cnt), 64'd16);
      chk("t2_mem0", 64'(dut_mem[0]), 64'h3000_0000);
      chk("t2_mem15", 64'(dut_mem[15]), 64'h3000_000F);
`endif
      wait_done("t2_done_seen", rst_n, run_n);

      // Abort on the 4th RUN cycle
      wq.delete();
      for (int i = 0; i < 3; i++) wq.push_back(32'h5000_0000 + 32'(i));
      load_seq(3);
      rc = 0;
      for (int c = 0; c < 40 && rc < 4; c++) begin
         @(negedge clk);
         if (run) rc++;
      end
      chk("t3_run_reached", 64'(rc), 64'd4);
      LoadInstructions = 1'b1;
      Instruction = 32'hABCD0001;
      @(negedge clk);
      LoadInstructions = 1'b0;
      chk("t3_run", 64'(run), 64'd0);
      chk("t3_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("t3_we", 64'(imem_we), 64'd1);
      chk("t3_waddr", 64'(imem_waddr), 64'd0);
      chk("t3_wdata", 64'(imem_wdata), 64'hABCD0001);
      chk("t3_count", 64'(count), 64'd1);
      wait_done("t3_done_seen", rst_n, run_n);

      // Reset during the 3rd LOAD cycle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         LoadInstructions = 1'b1;
         Instruction = 32'h4000_0000 + 32'(i);
      end
      @(negedge clk);
      Reset = 1'b0;
      Instruction = 32'hDEADBEEF;
      @(negedge clk);
      Reset = 1'b1;
      LoadInstructions = 1'b0;
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_we", 64'(imem_we), 64'd0);
      chk("t4_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("t4_done", 64'(done), 64'd0);
      we_n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (imem_we) we_n++;
      end
      chk("t4_no_writes", 64'(we_n), 64'd0);
      chk("t4_still_idle_run", 64'(run), 64'd0);

      // Single-word load from IDLE
      wq.delete();
      wq.push_back(32'h0000_0013);
      clear_log();
      load_seq(1);
      wait_done("t5_done_seen", rst_n, run_n);
      chk("t5_count", 64'(count), 64'd1);
      chk("t5_mem0", 64'(dut_mem[0]), 64'h0000_0013);
      chk("t5_run_cycles", 64'(run_n), 64'd10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 16, instruction memory depth in words; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-004 Parameter RST_CYCLES, default 2, CPU reset pulse length in cycles; at least 1.
REQ-005 Parameter RUN_CYCLES, default 10, CPU run window in cycles; at least 1.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 Reset  input  1  synchronous, active-low reset.
REQ-008 LoadInstructions  input  1  high = Instruction is valid this cycle.
REQ-009 Instruction  input  DATA_W  instruction word to store.
REQ-010 imem_we  output  1  instruction memory write strobe.
REQ-011 imem_waddr  output  ADDR_W  instruction memory write address.
REQ-012 imem_wdata  output  DATA_W  instruction memory write data.
REQ-013 cpu_reset  output  1  active-high reset to the CPU.
REQ-014 run  output  1  high while the CPU run window is open.
REQ-015 done  output  1  high once the run window has completed.
REQ-016 count  output  ADDR_W+1  number of words stored since the last load began.
REQ-017 overflow  output  1  sticky flag: a word arrived with count = DEPTH.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, CPURST, RUN and DONE, with all outputs registered.
REQ-019 In IDLE or DONE, LoadInstructions=1 SHALL move the FSM to LOAD and clear the write pointer, count and overflow; the word sampled in that cycle is the first word stored, at address 0.
REQ-020 Each sampled word SHALL produce imem_we=1 on the next cycle, with imem_waddr set to the write pointer and imem_wdata set to the sampled word (1-cycle latency).
REQ-021 After each stored word, the write pointer and count SHALL each increment by 1; count saturates at DEPTH.
REQ-022 A word arriving with count=DEPTH SHALL set overflow; without the wrap feature it is dropped and imem_we stays 0.
REQ-023 In LOAD, LoadInstructions=0 SHALL move the FSM to CPURST, even when count=0.
REQ-024 CPURST SHALL hold cpu_reset=1 for exactly RST_CYCLES cycles, then move to RUN.
REQ-025 RUN SHALL hold run=1 and cpu_reset=0 for exactly RUN_CYCLES cycles, then move to DONE.
REQ-026 DONE SHALL hold done=1 and cpu_reset=0 until LoadInstructions=1.
REQ-027 LoadInstructions=1 during CPURST or RUN SHALL abort the sequence: the FSM goes to LOAD as in REQ-019, cpu_reset=1, and run=0 from the next cycle.
REQ-028 In IDLE and LOAD, cpu_reset SHALL be 1, and run and done SHALL be 0.
REQ-029 The cycle counter SHALL be wide enough for max(RST_CYCLES, RUN_CYCLES) with no wrap before the terminal count.

Reset
REQ-030 Reset=0 at a rising edge SHALL force IDLE from any state, including mid-load and mid-run.
REQ-031 Reset values: imem_we=0, imem_waddr=0, imem_wdata=0, cpu_reset=1, run=0, done=0, count=0, overflow=0.
REQ-032 Words presented while Reset=0 SHALL be ignored.

Configuration
REQ-033 With LOADER_WRAP_EN defined, a word arriving at count=DEPTH SHALL be written at the wrapped write pointer (modulo DEPTH, overwriting from address 0), set overflow, and leave count at DEPTH.
REQ-034 Without LOADER_WRAP_EN, the behaviour in REQ-022 SHALL apply.

Verification
REQ-035 Reset low for 1 cycle -> all outputs at their REQ-031 values, and cpu_reset=1.
REQ-036 Load 11 words (0x200001A7 first, 0x00E24020 last), then drop LoadInstructions -> 11 writes at addresses 0..10 with matching data; count=11; cpu_reset=1 for 2 cycles; run=1 for 10 cycles; then done=1.
REQ-037 Load 18 words with DEPTH=16, macro undefined -> 16 writes; count=16; overflow=1; words 17 and 18 not written.
REQ-038 Same 18 words with LOADER_WRAP_EN defined -> words 17 and 18 written at addresses 0 and 1; count=16; overflow=1.
REQ-039 Assert LoadInstructions on the 4th RUN cycle -> run=0 and cpu_reset=1 on the next cycle; new word written at address 0; count=1.
REQ-040 Reset=0 on the 3rd LOAD cycle -> IDLE with count=0, and no imem_we on any following cycle.
